// File: rtl/bp_mem_stream_responder.sv
// bp_mem_stream_responder: BedRock stream memory endpoint over a dword array.
// Define BP_MEM_RESPONDER_DELAY_EN to insert delay_p idle cycles before each response.
module bp_mem_stream_responder #(
   parameter int header_width_p = 64,
   parameter int paddr_width_p  = 40,
   parameter int dword_width_p  = 64,
   parameter int els_p          = 1024,
   parameter int max_beats_p    = 8,
   parameter int delay_p        = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [header_width_p-1:0] mem_cmd_header_i,
   input  logic                      mem_cmd_header_v_i,
   output logic                      mem_cmd_header_ready_o,
   input  logic [dword_width_p-1:0]  mem_cmd_data_i,
   input  logic                      mem_cmd_data_v_i,
   output logic                      mem_cmd_data_ready_o,
   output logic [header_width_p-1:0] mem_resp_header_o,
   output logic                      mem_resp_header_v_o,
   input  logic                      mem_resp_header_yumi_i,
   output logic [dword_width_p-1:0]  mem_resp_data_o,
   output logic                      mem_resp_data_v_o,
   input  logic                      mem_resp_data_yumi_i
);

   localparam int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp    = $clog2(max_beats_p + 1);
   localparam int addr_lsb_lp = 4;
   localparam int size_lsb_lp = 4 + paddr_width_p;

   if (delay_p < 0 || max_beats_p < 1) begin : g_bad_param
      $error("bp_mem_stream_responder: illegal delay_p or max_beats_p");
   end

`ifdef BP_MEM_RESPONDER_DELAY_EN
   typedef enum logic [2:0] {
      READY, WR_DATA, RESP_HDR, RD_DATA, WAIT
   } state_e;
   localparam int dly_w_lp = (delay_p > 1) ? $clog2(delay_p) : 1;
   logic [dly_w_lp-1:0] dcnt_r, dcnt_n;
`else
   typedef enum logic [2:0] {
      READY, WR_DATA, RESP_HDR, RD_DATA
   } state_e;
`endif

   state_e                    state_r, state_n, done_st;
   logic [header_width_p-1:0] hdr_r;
   logic [cnt_w_lp-1:0]       cnt_r, cnt_n, beats;
   logic [dword_width_p-1:0]  mem [els_p];
   logic [lg_els_lp-1:0]      base, mask, raw, idx;
   logic                      hdr_ready, data_ready, hdr_v, data_v;
   logic                      cap, we, last, hdr_rd, in_wr;

   function automatic logic [cnt_w_lp-1:0] num_beats(input logic [2:0] s);
      int b;
      b = (s <= 3'd3) ? 1 : (1 << (s - 3'd3));
      if (b > max_beats_p) b = max_beats_p;
      return cnt_w_lp'(b);
   endfunction

   assign in_wr  = (mem_cmd_header_i[3:0] == 4'd1)
                || (mem_cmd_header_i[3:0] == 4'd3);
   assign hdr_rd = (hdr_r[3:0] == 4'd0) || (hdr_r[3:0] == 4'd2);
   assign beats  = num_beats(hdr_r[size_lsb_lp +: 3]);
   assign last   = (cnt_r == beats - 1'b1);

   // Critical word first: wrap the low bits of the index inside the block.
   always_comb begin
      base = hdr_r[addr_lsb_lp + 3 +: lg_els_lp];
      mask = lg_els_lp'(beats - 1'b1);
      raw  = (base & ~mask) | ((base + lg_els_lp'(cnt_r)) & mask);
      idx  = raw;
      if ({1'b0, raw} >= (lg_els_lp + 1)'(els_p))
         idx = raw - lg_els_lp'(els_p);
   end

   always_comb begin
      state_n    = state_r;
      cnt_n      = cnt_r;
      hdr_ready  = 1'b0;
      data_ready = 1'b0;
      hdr_v      = 1'b0;
      data_v     = 1'b0;
      cap        = 1'b0;
      we         = 1'b0;
      done_st    = RESP_HDR;
`ifdef BP_MEM_RESPONDER_DELAY_EN
      dcnt_n     = '0;
      if (delay_p > 0) done_st = WAIT;
`endif
      unique case (state_r)
         READY: begin
            hdr_ready = 1'b1;
            if (mem_cmd_header_v_i) begin
               cap     = 1'b1;
               cnt_n   = '0;
               state_n = in_wr ? WR_DATA : done_st;
            end
         end
         WR_DATA: begin
            data_ready = 1'b1;
            if (mem_cmd_data_v_i) begin
               we = 1'b1;
               if (last) state_n = done_st;
               else      cnt_n   = cnt_r + 1'b1;
            end
         end
         RESP_HDR: begin
            hdr_v = 1'b1;
            if (mem_resp_header_yumi_i) begin
               cnt_n   = '0;
               state_n = hdr_rd ? RD_DATA : READY;
            end
         end
         RD_DATA: begin
            data_v = 1'b1;
            if (mem_resp_data_yumi_i) begin
               if (last) state_n = READY;
               else      cnt_n   = cnt_r + 1'b1;
            end
         end
`ifdef BP_MEM_RESPONDER_DELAY_EN
         WAIT: begin
            dcnt_n = dcnt_r + 1'b1;
            if (dcnt_r == dly_w_lp'(delay_p - 1)) state_n = RESP_HDR;
         end
`endif
         default: state_n = READY;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= READY;
         cnt_r   <= '0;
         hdr_r   <= '0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         if (cap) hdr_r <= mem_cmd_header_i;
      end
   end

`ifdef BP_MEM_RESPONDER_DELAY_EN
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) dcnt_r <= '0;
      else            dcnt_r <= dcnt_n;
   end
`endif

   // Backing store keeps its contents across reset.
   always_ff @(posedge clk_i) begin
      if (we) mem[idx] <= mem_cmd_data_i;
   end

   assign mem_cmd_header_ready_o = hdr_ready & reset_n_i;
   assign mem_cmd_data_ready_o   = data_ready;
   assign mem_resp_header_o      = hdr_r;
   assign mem_resp_header_v_o    = hdr_v;
   assign mem_resp_data_v_o      = data_v;
   assign mem_resp_data_o        = data_v ? mem[idx] : '0;

endmodule

// File: tb/tb_bp_mem_stream_responder.sv
// tb_bp_mem_stream_responder: directed + random traffic against a dword-array model.
// Expected response latency follows BP_MEM_RESPONDER_DELAY_EN when defined.
module tb_bp_mem_stream_responder;

   localparam int ELS = 1024;
   localparam int MB  = 8;
   localparam int DLY = 4;
`ifdef BP_MEM_RESPONDER_DELAY_EN
   localparam int LAT = DLY + 1;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] cmd_hdr = '0;
   logic        cmd_hdr_v = 1'b0;
   logic        cmd_hdr_ready;
   logic [63:0] cmd_data = '0;
   logic        cmd_data_v = 1'b0;
   logic        cmd_data_ready;
   logic [63:0] resp_hdr;
   logic        resp_hdr_v;
   logic        resp_hdr_yumi = 1'b0;
   logic [63:0] resp_data;
   logic        resp_data_v;
   logic        resp_data_yumi = 1'b0;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] model [ELS];
   logic [63:0] wq [$];

   always #5 clk = ~clk;

   bp_mem_stream_responder #(
      .header_width_p(64), .paddr_width_p(40), .dword_width_p(64),
      .els_p(ELS), .max_beats_p(MB), .delay_p(DLY)
   ) dut (
      .clk_i                  (clk),
      .reset_n_i              (rst_n),
      .mem_cmd_header_i       (cmd_hdr),
      .mem_cmd_header_v_i     (cmd_hdr_v),
      .mem_cmd_header_ready_o (cmd_hdr_ready),
      .mem_cmd_data_i         (cmd_data),
      .mem_cmd_data_v_i       (cmd_data_v),
      .mem_cmd_data_ready_o   (cmd_data_ready),
      .mem_resp_header_o      (resp_hdr),
      .mem_resp_header_v_o    (resp_hdr_v),
      .mem_resp_header_yumi_i (resp_hdr_yumi),
      .mem_resp_data_o        (resp_data),
      .mem_resp_data_v_o      (resp_data_v),
      .mem_resp_data_yumi_i   (resp_data_yumi)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mk_hdr(input logic [3:0] t,
                                          input logic [39:0] a,
                                          input logic [2:0] s);
      logic [63:0] h;
      h = {$urandom, $urandom};
      h[3:0]   = t;
      h[43:4]  = a;
      h[46:44] = s;
      return h;
   endfunction

   function automatic int nbeats(input int s);
      int b;
      b = (s <= 3) ? 1 : (1 << (s - 3));
      return (b > MB) ? MB : b;
   endfunction

   // Dword index of beat k: wrap inside the naturally aligned block.
   function automatic int idx_of(input logic [39:0] a, input int s,
                                 input int k);
      int base, b, off;
      base = int'(a[12:3]);
      b    = nbeats(s);
      off  = base % b;
      return ((base - off) + (off + k) % b) % ELS;
   endfunction

   task automatic send_hdr(input logic [63:0] h);
      int ok;
      ok = 0;
      cmd_hdr   = h;
      cmd_hdr_v = 1'b1;
      for (int i = 0; i < 50 && ok == 0; i++) begin
         if (cmd_hdr_ready) ok = 1;
         tick();
      end
      cmd_hdr_v = 1'b0;
      chk("hdr_accepted", 64'(ok), 64'd1);
   endtask

   task automatic send_beats(input logic [39:0] a, input int s,
                             input int n);
      int ok;
      for (int k = 0; k < n; k++) begin
         ok = 0;
         cmd_data   = wq[k];
         cmd_data_v = 1'b1;
         for (int i = 0; i < 50 && ok == 0; i++) begin
            if (cmd_data_ready) ok = 1;
            tick();
         end
         chk("beat_accepted", 64'(ok), 64'd1);
         if (ok == 1) model[idx_of(a, s, k)] = wq[k];
      end
      cmd_data_v = 1'b0;
   endtask

   task automatic get_resp(input logic [63:0] h, input int rd,
                           input int hold);
      int          n;
      int          s;
      logic [39:0] a;
      logic [63:0] e;
      n = 1;
      a = h[43:4];
      s = int'(h[46:44]);
      while (!resp_hdr_v && n < 60) begin
         tick();
         n++;
      end
      chk("resp_hdr_v", 64'(resp_hdr_v), 64'd1);
      chk("resp_latency", 64'(n), 64'(LAT));
      chk("resp_hdr", resp_hdr, h);
      chk("data_v_in_hdr", 64'(resp_data_v), 64'd0);
      resp_hdr_yumi = 1'b1;
      tick();
      resp_hdr_yumi = 1'b0;
      for (int k = 0; k < (rd ? nbeats(s) : 0); k++) begin
         e = model[idx_of(a, s, k)];
         for (int j = 0; j < hold; j++) begin
            chk("hold_v", 64'(resp_data_v), 64'd1);
            chk("hold_data", resp_data, e);
            chk("hold_hdr_ready", 64'(cmd_hdr_ready), 64'd0);
            tick();
         end
         chk("beat_v", 64'(resp_data_v), 64'd1);
         chk("beat_data", resp_data, e);
         resp_data_yumi = 1'b1;
         tick();
         resp_data_yumi = 1'b0;
      end
      chk("idle_data_v", 64'(resp_data_v), 64'd0);
      chk("idle_hdr_ready", 64'(cmd_hdr_ready), 64'd1);
   endtask

   task automatic do_write(input logic [3:0] t, input logic [39:0] a,
                           input logic [2:0] s);
      logic [63:0] h;
      h = mk_hdr(t, a, s);
      send_hdr(h);
      send_beats(a, int'(s), nbeats(int'(s)));
      get_resp(h, 0, 0);
   endtask

   task automatic do_read(input logic [3:0] t, input logic [39:0] a,
                          input logic [2:0] s, input int hold);
      logic [63:0] h;
      h = mk_hdr(t, a, s);
      send_hdr(h);
      get_resp(h, 1, hold);
   endtask

   initial begin
      logic [63:0] h;
      logic [3:0]  t;
      logic [39:0] a;
      logic [2:0]  s;

      #2;
      chk("rst_hdr_ready", 64'(cmd_hdr_ready), 64'd0);
      chk("rst_data_ready", 64'(cmd_data_ready), 64'd0);
      chk("rst_resp_v", 64'(resp_hdr_v), 64'd0);
      chk("rst_data_v", 64'(resp_data_v), 64'd0);
      chk("rst_resp_hdr", resp_hdr, 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 64'(cmd_hdr_ready), 64'd1);

      // Fill the whole array so every later read has a known value.
      for (int b = 0; b < ELS / MB; b++) begin
         wq.delete();
         for (int k = 0; k < MB; k++) wq.push_back({$urandom, $urandom});
         do_write(4'd1, 40'(b * 64), 3'd6);
      end

      wq.delete();
      wq.push_back(64'hDEADBEEF_01234567);
      do_write(4'd1, 40'h80, 3'd3);
      do_read(4'd0, 40'h80, 3'd3, 0);
      chk("plan_rd80", model[16], 64'hDEADBEEF_01234567);

      wq.delete();
      for (int k = 0; k < 8; k++) wq.push_back(64'(16 + k));
      do_write(4'd1, 40'h100, 3'd6);
      do_read(4'd0, 40'h118, 3'd6, 5);
      chk("plan_wrap_first", 64'(idx_of(40'h118, 6, 0)), 64'd35);
      chk("plan_wrap_last", 64'(idx_of(40'h118, 6, 7)), 64'd34);

      h = mk_hdr(4'd7, 40'h140, 3'd6);
      send_hdr(h);
      cmd_data   = 64'h5A5A;
      cmd_data_v = 1'b1;
      #1;
      chk("other_data_ready", 64'(cmd_data_ready), 64'd0);
      get_resp(h, 0, 0);
      cmd_data_v = 1'b0;

      for (int r = 0; r < 24; r++) begin
         t = 4'($urandom_range(0, 3));
         a = 40'({$urandom, $urandom});
         s = 3'($urandom_range(0, 7));
         wq.delete();
         for (int k = 0; k < MB; k++) wq.push_back({$urandom, $urandom});
         if (t == 4'd1 || t == 4'd3) do_write(t, a, s);
         else do_read(t, a, s, int'($urandom_range(0, 2)));
      end

      // Reset lands while the third beat of a block write is presented.
      wq.delete();
      for (int k = 0; k < 8; k++) wq.push_back(64'hA000 + 64'(k));
      h = mk_hdr(4'd1, 40'h200, 3'd6);
      send_hdr(h);
      send_beats(40'h200, 6, 2);
      cmd_data   = 64'hBAD;
      cmd_data_v = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hdr_ready", 64'(cmd_hdr_ready), 64'd0);
      chk("mid_rst_data_ready", 64'(cmd_data_ready), 64'd0);
      chk("mid_rst_resp_v", 64'(resp_hdr_v), 64'd0);
      chk("mid_rst_resp_hdr", resp_hdr, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      cmd_data_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rel_hdr_ready", 64'(cmd_hdr_ready), 64'd1);
         chk("rel_resp_v", 64'(resp_hdr_v), 64'd0);
      end
      do_read(4'd2, 40'h200, 3'd6, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
